// File: rtl/seq_mul_shift_add.sv
// seq_mul_shift_add: sequential shift-and-add multiplier with a fixed latency.
// One multiplier bit is consumed per clock in CALC, so a WIDTH x WIDTH product
// takes WIDTH CALC cycles regardless of operand values.
// Handshake: start (sampled in IDLE only), busy (registered, high in CALC),
// done (one-cycle pulse). The product register holds until the next completion.
// Optional build macro SEQ_MUL_SIGNED_EN adds a signed_mode input for
// two's complement operands. Without it the unit is unsigned only.
module seq_mul_shift_add #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic                 signed_mode,
`endif
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW   = 2 * WIDTH;
  // One extra bit so the count never wraps before reaching WIDTH-1.
  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]    product_q, product_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_step;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    result;

  assign accept    = (state_q == StIdle) && start;
  assign last_step = (state_q == StCalc) && (cnt_q == CntW'(WIDTH - 1));

  // Partial-product accumulate for the current multiplier bit.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SEQ_MUL_SIGNED_EN
  logic sign_q, sign_d;
  logic sign_in;

  // Operand magnitudes and result sign. The most negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  always_comb begin
    a_mag   = a_in;
    b_mag   = b_in;
    sign_in = 1'b0;
    if (signed_mode) begin
      if (a_in[WIDTH-1]) a_mag = -a_in;
      if (b_in[WIDTH-1]) b_mag = -b_in;
      sign_in = a_in[WIDTH-1] ^ b_in[WIDTH-1];
    end
  end

  // Sign of the operation in flight, captured with the operands.
  always_comb begin
    sign_d = sign_q;
    if (accept) sign_d = sign_in;
  end

  // Sign register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end

  assign result = sign_q ? -acc_sum : acc_sum;
`else
  assign a_mag  = a_in;
  assign b_mag  = b_in;
  assign result = acc_sum;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; any unused encoding falls back to IDLE.
  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:  state_d = start ? StCalc : StIdle;
      StCalc:  state_d = last_step ? StDone : StCalc;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered handshake outputs, derived from the state being entered.
  always_comb begin
    busy_d = (state_d == StCalc);
    done_d = (state_d == StDone);
  end

  // Datapath next-state: capture in IDLE, shift-and-add in CALC.
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = PW'(a_mag);
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      StCalc: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        // Final edge: publish the sum including this cycle's partial product.
        if (last_step) product_d = result;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mul_shift_add.sv
// Bench for seq_mul_shift_add: a WIDTH=16 and a WIDTH=4 instance, each with a
// scoreboard queue filled at start acceptance and drained on every done pulse.
module tb_seq_mul_shift_add;

  logic        clk;
  logic        rst_n;

  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] product16;

  logic        start4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  product4;

  logic [63:0] sb16[$];
  logic [63:0] sb4[$];

  int n_checks = 0;
  int n_fail   = 0;

  seq_mul_shift_add #(.WIDTH(16)) u_dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start16),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_mode(sm16),
`endif
    .a_in       (a16),
    .b_in       (b16),
    .busy       (busy16),
    .done       (done16),
    .product    (product16)
  );

  seq_mul_shift_add #(.WIDTH(4)) u_dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
`ifdef SEQ_MUL_SIGNED_EN
    .signed_mode(1'b0),
`endif
    .a_in       (a4),
    .b_in       (b4),
    .busy       (busy4),
    .done       (done4),
    .product    (product4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drains: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done16) begin
      if (sb16.size() == 0) check_eq("sb16_unexpected_done", 64'(done16), 64'd0);
      else check_eq("product16", 64'(product16), sb16.pop_front());
    end
    if (rst_n && done4) begin
      if (sb4.size() == 0) check_eq("sb4_unexpected_done", 64'(done4), 64'd0);
      else check_eq("product4", 64'(product4), sb4.pop_front());
    end
  end

  // One WIDTH=16 operation: accept, check latency/busy span, done width and hold.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input string tag);
    logic [31:0] e;
    int n;
    int busy_cnt;
    bit seen;
    if (sm) e = 32'(int'($signed(a)) * int'($signed(b)));
    else    e = 32'(a) * 32'(b);
    a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
    @(posedge clk);
    sb16.push_back(64'(e));
    #1;
    start16 = 1'b0;
    // Later operand changes must not matter.
    a16 = ~a; b16 = ~b; sm16 = ~sm;
    busy_cnt = busy16 ? 1 : 0;
    n = 0;
    seen = 0;
    while (!seen && n < 24) begin
      @(posedge clk); #1;
      n++;
      if (done16) seen = 1;
      else if (busy16) busy_cnt++;
    end
    check_eq({tag, "_latency"}, 64'(n), 64'd16);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd16);
    check_eq({tag, "_busy_at_done"}, 64'(busy16), 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_done_width"}, 64'(done16), 64'd0);
    check_eq({tag, "_hold"}, 64'(product16), 64'(e));
  endtask

  // One WIDTH=4 operation with latency check.
  task automatic run4(input logic [3:0] a, input logic [3:0] b);
    int n;
    bit seen;
    a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk);
    sb4.push_back(64'(8'(a) * 8'(b)));
    #1;
    start4 = 1'b0;
    a4 = ~a; b4 = ~b;
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      @(posedge clk); #1;
      n++;
      if (done4) seen = 1;
    end
    if (n != 4) check_eq("w4_latency", 64'(n), 64'd4);
    else n_checks++;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, d1, d2;
    rst_n = 1'b0;
    start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(busy16), 64'd0);
    check_eq("rst_done", 64'(done16), 64'd0);
    check_eq("rst_product", 64'(product16), 64'd0);
    check_eq("rst_product4", 64'(product4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run16(16'd17, 16'd5, 1'b0, "17x5");
    repeat (3) @(posedge clk);
    #1;
    check_eq("17x5_still_held", 64'(product16), 64'd85);
    run16(16'hFFFF, 16'hFFFF, 1'b0, "max_x_max");
    run16(16'd0, 16'd1234, 1'b0, "zero_x_1234");
    run16(16'hA5C3, 16'h3C5A, 1'b0, "mixed");

    // start held through CALC and DONE: second op accepted only back in IDLE.
    sb16.push_back(64'd12);
    sb16.push_back(64'd81);
    a16 = 16'd3; b16 = 16'd4; start16 = 1'b1;
    @(posedge clk); #1;
    a16 = 16'd9; b16 = 16'd9;
    n = 0; d1 = 0; d2 = 0;
    while (d2 == 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done16) begin
        if (d1 == 0) d1 = n;
        else d2 = n;
      end
    end
    start16 = 1'b0;
    check_eq("held_first_done", 64'(d1), 64'd16);
    check_eq("held_second_done", 64'(d2), 64'd34);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a computation.
    a16 = 16'd40000; b16 = 16'd3; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy16), 64'd0);
    check_eq("midrst_done", 64'(done16), 64'd0);
    check_eq("midrst_product", 64'(product16), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("postrst_product", 64'(product16), 64'd0);
    run16(16'd6, 16'd7, 1'b0, "6x7_after_reset");

`ifdef SEQ_MUL_SIGNED_EN
    run16(16'hFFFD, 16'd5, 1'b1, "s_m3x5");
    check_eq("s_m3x5_value", 64'(product16), 64'hFFFF_FFF1);
    run16(16'h8000, 16'h8000, 1'b1, "s_minxmin");
    check_eq("s_minxmin_value", 64'(product16), 64'h4000_0000);
    run16(16'hFFFD, 16'd5, 1'b0, "u_fffdx5");
    check_eq("u_fffdx5_value", 64'(product16), 64'h0004_FFF1);
    run16(16'd7, 16'hFFF9, 1'b1, "s_7xm7");
`endif

    // WIDTH=4: corner first, then every operand pair.
    run4(4'd15, 4'd15);
    check_eq("w4_15x15", 64'(product4), 64'hE1);
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run4(4'(i), 4'(j));
      end
    end

    repeat (4) @(posedge clk);
    check_eq("sb16_drained", 64'(sb16.size()), 64'd0);
    check_eq("sb4_drained", 64'(sb4.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
